// File: rtl/svo_tmds_dec_if.sv
// Pixel-domain bundle between a TMDS lane deserializer and the TMDS decoder.
// The slave side is the decoder. The master side supplies raw words and consumes decoded symbols.
interface svo_tmds_dec_if;
  logic [9:0] din;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] dout;
  logic       locked;
  logic [3:0] offset;

  modport master (
    output din,
    input  de,
    input  ctrl,
    input  dout,
    input  locked,
    input  offset
  );

  modport slave (
    input  din,
    output de,
    output ctrl,
    output dout,
    output locked,
    output offset
  );
endinterface

// File: rtl/svo_tmds_dec.sv
// TMDS receive decoder for one lane: bit-aligns unaligned 10-bit words by hunting for runs of
// control tokens, then decodes each symbol into de/ctrl/8-bit data with a two-stage pipeline.
module svo_tmds_dec #(
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned CTRL_RUN      = 32,
  parameter int unsigned LOSS_TIMEOUT  = 4096
) (
  input logic          clk_pixel,
  input logic          resetn,
  svo_tmds_dec_if.slave bus
);

  localparam int unsigned WinW = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int unsigned RunW = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
  localparam int unsigned ToW  = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [WinW-1:0] WinLast = WinW'(SEARCH_WINDOW - 1);
  localparam logic [RunW-1:0] RunLast = RunW'(CTRL_RUN - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(LOSS_TIMEOUT - 1);

  typedef enum logic {StSearch, StLocked} state_e;

  state_e          state_q, state_d;
  logic [9:0]      din_q;
  logic [3:0]      offset_q, offset_d;
  logic [WinW-1:0] win_cnt_q, win_cnt_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;

  logic [9:0]      sym_q, sym_d;
  logic            tok_q, tok_d;
  logic [1:0]      tok_ctrl_q, tok_ctrl_d;

  logic            de_q, de_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [7:0]      dout_q, dout_d;

  logic [19:0]     hist;
  logic [7:0]      q_bits;
  logic [7:0]      data_dec;
  logic            locked_d;

  // Stage 1: pick the aligned symbol out of the two-word history and flag control tokens.
  always_comb begin
    hist       = {bus.din, din_q};
    sym_d      = hist[offset_q +: 10];
    tok_d      = 1'b1;
    tok_ctrl_d = 2'b00;
    case (sym_d)
      10'h354: tok_ctrl_d = 2'b00;
      10'h0AB: tok_ctrl_d = 2'b01;
      10'h154: tok_ctrl_d = 2'b10;
      10'h2AB: tok_ctrl_d = 2'b11;
      default: tok_d      = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR chain selected by bit 8.
  always_comb begin
    q_bits      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    data_dec    = '0;
    data_dec[0] = q_bits[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = sym_q[8] ? (q_bits[i] ^ q_bits[i-1]) : ~(q_bits[i] ^ q_bits[i-1]);
    end
  end

  // Alignment FSM; counters are driven by the stage-1 token flag.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    win_cnt_d = win_cnt_q;
    run_cnt_d = run_cnt_q;
    to_cnt_d  = to_cnt_q;
    unique case (state_q)
      StSearch: begin
        win_cnt_d = win_cnt_q + 1'b1;
        run_cnt_d = tok_q ? run_cnt_q + 1'b1 : '0;
        if (tok_q && (run_cnt_q == RunLast)) begin
          // A completed run wins over a window expiring in the same cycle.
          state_d   = StLocked;
          to_cnt_d  = '0;
          win_cnt_d = '0;
          run_cnt_d = '0;
        end else if (win_cnt_q == WinLast) begin
          offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          win_cnt_d = '0;
          run_cnt_d = '0;
        end
      end
      StLocked: begin
        if (tok_q) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == ToLast) begin
          state_d   = StSearch;
          win_cnt_d = '0;
          run_cnt_d = '0;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Gate on the next lock state so outputs and locked change on the same edge.
  always_comb begin
    locked_d = (state_d == StLocked);
    de_d     = 1'b0;
    ctrl_d   = ctrl_q;
    dout_d   = '0;
    if (!locked_d) begin
      ctrl_d = 2'b00;
    end else if (tok_q) begin
      ctrl_d = tok_ctrl_q;
    end else begin
      de_d   = 1'b1;
      dout_d = data_dec;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      state_q    <= StSearch;
      din_q      <= '0;
      offset_q   <= '0;
      win_cnt_q  <= '0;
      run_cnt_q  <= '0;
      to_cnt_q   <= '0;
      sym_q      <= '0;
      tok_q      <= 1'b0;
      tok_ctrl_q <= 2'b00;
      de_q       <= 1'b0;
      ctrl_q     <= 2'b00;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      din_q      <= bus.din;
      offset_q   <= offset_d;
      win_cnt_q  <= win_cnt_d;
      run_cnt_q  <= run_cnt_d;
      to_cnt_q   <= to_cnt_d;
      sym_q      <= sym_d;
      tok_q      <= tok_d;
      tok_ctrl_q <= tok_ctrl_d;
      de_q       <= de_d;
      ctrl_q     <= ctrl_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.de     = de_q;
  assign bus.ctrl   = ctrl_q;
  assign bus.dout   = dout_q;
  assign bus.locked = (state_q == StLocked);
  assign bus.offset = offset_q;

endmodule

// File: tb/tb_svo_tmds_dec.sv
// Directed bench for svo_tmds_dec: symbols are pushed through a bit-shift model of the
// deserializer and every output is checked against hand-derived values and cycle counts.
module tb_svo_tmds_dec;

  logic clk_pixel = 1'b0;
  logic resetn    = 1'b0;
  int   n_err     = 0;
  int   n_chk     = 0;
  int   shift     = 0;
  logic [9:0] prev_sym = '0;

  svo_tmds_dec_if bus ();

  svo_tmds_dec dut (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Symbol s lands in the word stream 'shift' bits late; decoder offset 'shift' recovers it.
  task automatic send(input logic [9:0] s);
    logic [19:0] pair;
    pair     = {s, prev_sym} >> (10 - shift);
    bus.din  = pair[9:0];
    prev_sym = s;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    bus.din  = '0;
    prev_sym = '0;
    @(posedge clk_pixel);
    #1;
    resetn = 1'b1;
  endtask

  task automatic chk_gated(input string tag);
    chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk({tag, "_de"},     32'(bus.de),     32'd0);
    chk({tag, "_ctrl"},   32'(bus.ctrl),   32'd0);
    chk({tag, "_dout"},   32'(bus.dout),   32'd0);
  endtask

  initial begin
    int n;
    bus.din = '0;
    @(posedge clk_pixel);
    #1;
    do_reset();
    chk_gated("reset");
    chk("reset_offset", 32'(bus.offset), 32'd0);

    // Offset-0 token stream: lock appears after the 34th word (32nd token + 2 stages).
    shift = 0;
    repeat (33) send(10'h354);
    chk("run_before_lock", 32'(bus.locked), 32'd0);
    send(10'h354);
    chk("run_lock", 32'(bus.locked), 32'd1);
    chk("run_lock_ctrl", 32'(bus.ctrl), 32'd0);
    chk("run_lock_de", 32'(bus.de), 32'd0);
    repeat (6) send(10'h354);
    send(10'h2AB);
    send(10'h354);
    chk("tok11_latency", 32'(bus.ctrl), 32'd0);
    send(10'h354);
    chk("tok11_ctrl", 32'(bus.ctrl), 32'd3);

    // Data decode; ctrl holds the last token value across data.
    send(10'h2AB);
    send(10'h100);
    send(10'h2FF);
    chk("pre_data_ctrl", 32'(bus.ctrl), 32'd3);
    send(10'h1F0);
    chk("d100_de", 32'(bus.de), 32'd1);
    chk("d100_dout", 32'(bus.dout), 32'h00);
    chk("d100_ctrl", 32'(bus.ctrl), 32'd3);
    send(10'h354);
    chk("d2ff_de", 32'(bus.de), 32'd1);
    chk("d2ff_dout", 32'(bus.dout), 32'hFE);
    send(10'h354);
    chk("d1f0_dout", 32'(bus.dout), 32'h10);
    send(10'h354);
    chk("tok00_de", 32'(bus.de), 32'd0);
    chk("tok00_dout", 32'(bus.dout), 32'h00);
    chk("tok00_ctrl", 32'(bus.ctrl), 32'd0);

    // No tokens: offset slips every 2048 cycles and wraps 9 -> 0.
    do_reset();
    repeat (2047) send(10'h000);
    chk("slip_not_yet", 32'(bus.offset), 32'd0);
    send(10'h000);
    chk("slip_first", 32'(bus.offset), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      repeat (2048) send(10'h000);
      chk($sformatf("slip_%0d", k), 32'(bus.offset), 32'(k % 10));
      chk($sformatf("slip_%0d_locked", k), 32'(bus.locked), 32'd0);
    end
    repeat (31) send(10'h354);
    repeat (40) send(10'h000);
    chk("run31_no_lock", 32'(bus.locked), 32'd0);
    repeat (33) send(10'h354);
    chk("run_restart_before", 32'(bus.locked), 32'd0);
    send(10'h354);
    chk("run_restart_lock", 32'(bus.locked), 32'd1);

    // Stream delayed by 3 bits: offsets 0..2 each burn a window, then 32 tokens lock.
    do_reset();
    shift = 3;
    n = 0;
    while (!bus.locked && n < 4 * 2048 + 32) begin
      send(10'h354);
      n++;
    end
    chk("shift3_locked", 32'(bus.locked), 32'd1);
    chk("shift3_cycles", 32'(n), 32'd6177);
    chk("shift3_offset", 32'(bus.offset), 32'd3);
    send(10'h1F0);
    send(10'h2AB);
    send(10'h2AB);
    chk("shift3_de", 32'(bus.de), 32'd1);
    chk("shift3_dout", 32'(bus.dout), 32'h10);

    // Data only: lock drops on the 4096th non-token symbol evaluated.
    repeat (4097) send(10'h1F0);
    chk("loss_before", 32'(bus.locked), 32'd1);
    chk("loss_before_ctrl", 32'(bus.ctrl), 32'd3);
    chk("loss_before_dout", 32'(bus.dout), 32'h10);
    send(10'h1F0);
    chk_gated("loss");
    chk("loss_offset", 32'(bus.offset), 32'd3);

    // Re-acquire at offset 7 (four more slips from 3), then a one-cycle reset.
    shift = 7;
    n = 0;
    while (!bus.locked && n < 5 * 2048 + 64) begin
      send(10'h354);
      n++;
    end
    chk("shift7_locked", 32'(bus.locked), 32'd1);
    chk("shift7_cycles", 32'(n), 32'd8225);
    chk("shift7_offset", 32'(bus.offset), 32'd7);
    do_reset();
    chk_gated("midlock_reset");
    chk("midlock_reset_offset", 32'(bus.offset), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
